// File: rtl/fft_result_unloader.sv
// Streams the final FFT result out of the mem1/mem2 ping-pong bank pairs as a
// valid/ready sample stream. Optional macro FFT_UNLOAD_NATURAL_ORDER_EN selects natural bin order.
module fft_result_unloader #(
  parameter int LOG2N  = 10,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_src_mem1,
  output logic [LOG2N-2:0]    o_rd_addr,
  output logic [3:0]          o_rd_en,
  input  logic [DATA_W-1:0]   i_rd_data_a,
  input  logic [DATA_W-1:0]   i_rd_data_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_W-1:0]   o_data,
  output logic [LOG2N-1:0]    o_bin,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [LOG2N:0]   cnt_q, cnt_d;
  logic             src_q, src_d;
  logic             done_q, done_d;

  logic             rd_pend_q, rd_bank_q, rd_last_q;
  logic [LOG2N-1:0] rd_bin_q;

  logic [1:0][DATA_W-1:0] fifo_data_q;
  logic [1:0][LOG2N-1:0]  fifo_bin_q;
  logic [1:0]             fifo_last_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             fifo_cnt_q;

  logic [LOG2N-1:0] idx, pos, bin;
  logic             issue, issue_last, push, pop;
  logic [2:0]       slots_used;
  logic [DATA_W-1:0] push_data;

  assign idx = cnt_q[LOG2N-1:0];
`ifdef FFT_UNLOAD_NATURAL_ORDER_EN
  assign pos = bitrev(idx);
  assign bin = idx;
`else
  assign pos = idx;
  assign bin = bitrev(idx);
`endif
  assign issue_last = (idx == '1);

  assign push      = rd_pend_q;
  assign push_data = rd_bank_q ? i_rd_data_b : i_rd_data_a;
  assign pop       = o_valid && i_ready;

  // A pop this cycle frees its slot before the new read can land, which keeps
  // one sample per cycle with only two entries of buffering.
  assign slots_used = {1'b0, fifo_cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign issue      = (state_q == S_RUN) && !cnt_q[LOG2N] && (slots_used < 3'd2);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    o_rd_en   = 4'b0000;
    o_rd_addr = '0;
    if (issue) begin
      o_rd_addr = pos[LOG2N-1:1];
      case ({src_q, pos[0]})
        2'b10:   o_rd_en = 4'b0001;
        2'b11:   o_rd_en = 4'b0010;
        2'b00:   o_rd_en = 4'b0100;
        default: o_rd_en = 4'b1000;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_RUN;
        cnt_d   = '0;
        src_d   = i_src_mem1;
      end
      S_RUN: if (issue) begin
        cnt_d = cnt_q + (LOG2N+1)'(1);
        if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (pop && o_last) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      src_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_bin_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      done_q    <= done_d;
      rd_pend_q <= issue;
      rd_bank_q <= pos[0];
      rd_last_q <= issue_last;
      rd_bin_q  <= bin;
    end
  end

  // NOTE: the two FIFO entries are reset so the payload outputs read zero out of reset;
  // a deep RAM-based buffer would be left unreset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_data_q <= '0;
      fifo_bin_q  <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_bin_q[wr_ptr_q]  <= rd_bin_q;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign o_valid = (fifo_cnt_q != 2'd0);
  assign o_data  = fifo_data_q[rd_ptr_q];
  assign o_bin   = fifo_bin_q[rd_ptr_q];
  assign o_last  = fifo_last_q[rd_ptr_q];
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Self-checking bench for fft_result_unloader: bank memory model, order model and
// cycle-by-cycle stream monitor. Honours FFT_UNLOAD_NATURAL_ORDER_EN like the design.
module tb_fft_result_unloader;

  localparam int LOG2N  = 10;
  localparam int N      = 1 << LOG2N;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start, i_src_mem1, i_ready;
  logic [LOG2N-2:0]  o_rd_addr;
  logic [3:0]        o_rd_en;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              o_valid, o_last, o_busy, o_done;
  logic [DATA_W-1:0] o_data;
  logic [LOG2N-1:0]  o_bin;

  always #5 clk = ~clk;

  fft_result_unloader #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_src_mem1(i_src_mem1),
    .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en),
    .i_rd_data_a(rd_a), .i_rd_data_b(rd_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_bin(o_bin),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  // memories indexed by position m: bank a address p holds m=2p, bank b holds m=2p+1
  logic [DATA_W-1:0] mem1 [N];
  logic [DATA_W-1:0] mem2 [N];

  initial begin rd_a = '0; rd_b = '0; end
  always @(posedge clk) begin
    if (o_rd_en[0]) rd_a <= mem1[{o_rd_addr, 1'b0}];
    if (o_rd_en[1]) rd_b <= mem1[{o_rd_addr, 1'b1}];
    if (o_rd_en[2]) rd_a <= mem2[{o_rd_addr, 1'b0}];
    if (o_rd_en[3]) rd_b <= mem2[{o_rd_addr, 1'b1}];
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // n-th sample of an unload: which memory position it comes from and which bin it is
  function automatic logic [LOG2N-1:0] model_pos(input int n);
`ifdef FFT_UNLOAD_NATURAL_ORDER_EN
    return rev(LOG2N'(n));
`else
    return LOG2N'(n);
`endif
  endfunction

  function automatic logic [LOG2N-1:0] model_bin(input int n);
`ifdef FFT_UNLOAD_NATURAL_ORDER_EN
    return LOG2N'(n);
`else
    return rev(LOG2N'(n));
`endif
  endfunction

  // ---------------- monitor ----------------
  int  cyc = 0;
  always @(posedge clk) cyc++;

  bit  mon_en = 0;
  bit  exp_src = 1;
  int  xfer_cnt, iss_cnt, done_cnt, busy_rise_cyc, first_valid_cyc, done_cyc;
  logic prev_valid, prev_ready, prev_busy, done_exp, prev_last;
  logic [DATA_W-1:0] prev_data;
  logic [LOG2N-1:0]  prev_bin;
  logic [DATA_W-1:0] got_data [N];
  logic [LOG2N-1:0]  got_bin  [N];
  logic              got_last [N];

  task automatic mon_reset();
    xfer_cnt = 0; iss_cnt = 0; done_cnt = 0;
    busy_rise_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    prev_valid = 0; prev_ready = 0; prev_busy = 0; done_exp = 0; prev_last = 0;
    prev_data = '0; prev_bin = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [LOG2N-1:0]  p;
      logic [3:0]        en_exp;
      logic [DATA_W-1:0] d_exp;
      if (o_busy && !prev_busy) busy_rise_cyc = cyc;
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

      if (o_rd_en != 4'b0) begin
        if (iss_cnt >= N) check("extra_read", 64'(iss_cnt), 64'(N - 1));
        else begin
          p = model_pos(iss_cnt);
          en_exp = exp_src ? (p[0] ? 4'b0010 : 4'b0001) : (p[0] ? 4'b1000 : 4'b0100);
          check("rd_port", {o_rd_en, o_rd_addr}, {en_exp, p[LOG2N-1:1]});
        end
        iss_cnt++;
      end else if (!o_busy) begin
        check("rd_idle", {o_rd_en, o_rd_addr}, '0);
      end

      if (prev_valid && !prev_ready)
        check("hold_stable", {o_valid, o_data, o_bin, o_last}, {1'b1, prev_data, prev_bin, prev_last});

      check("done_pulse", o_done, done_exp);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_with_done", o_busy, 1'b0);
      end
      done_exp = 1'b0;

      if (o_valid && i_ready) begin
        if (xfer_cnt >= N) check("extra_sample", 64'(xfer_cnt), 64'(N - 1));
        else begin
          p = model_pos(xfer_cnt);
          d_exp = exp_src ? mem1[p] : mem2[p];
          check("sample", {o_data, o_bin, o_last},
                {d_exp, model_bin(xfer_cnt), (xfer_cnt == N - 1)});
          got_data[xfer_cnt] = o_data;
          got_bin[xfer_cnt]  = o_bin;
          got_last[xfer_cnt] = o_last;
        end
        done_exp = o_last;
        xfer_cnt++;
      end
      if (o_rd_en != 4'b0) check("outstanding_le2", 64'(iss_cnt - xfer_cnt <= 2), 64'(1));

      prev_valid = o_valid; prev_ready = i_ready; prev_busy = o_busy;
      prev_data = o_data; prev_bin = o_bin; prev_last = o_last;
    end
  end

  // ---------------- ready driver ----------------
  int ready_mode = 0;  // 0: always 1, 1: pattern 1,0,0,1, 2: held 0
  int ready_ph = 0;
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       i_ready = (ready_ph == 0) || (ready_ph == 3);
        2:       i_ready = 1'b0;
        default: i_ready = 1'b1;
      endcase
      ready_ph = (ready_ph + 1) % 4;
    end
  end

  // ---------------- helpers ----------------
  task automatic fill(input bit result_in_mem1);
    for (int m = 0; m < N; m++) begin
      mem1[m] = result_in_mem1 ? DATA_W'(m) : (32'hBAD1_0000 | DATA_W'(m));
      mem2[m] = result_in_mem1 ? (32'hBAD2_0000 | DATA_W'(m)) : DATA_W'(m);
    end
  endtask

  task automatic start_run(input bit src);
    @(posedge clk); #1;
    mon_reset();
    exp_src = src;
    mon_en = 1;
    i_src_mem1 = src;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", 64'(done_cnt != 0), 64'(1));
    repeat (3) @(posedge clk);
  endtask

  task automatic check_full_run(input string tag, input bit timing);
    check({tag, "_samples"}, 64'(xfer_cnt), 64'(N));
    check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    check({tag, "_reads"}, 64'(iss_cnt), 64'(N));
    if (timing) begin
      check({tag, "_first_valid_lat"}, 64'(first_valid_cyc - busy_rise_cyc), 64'(2));
      check({tag, "_total_cycles"}, 64'(done_cyc - busy_rise_cyc), 64'(N + 2));
    end
  endtask

  // hand-computed literal points with position m holding value m
  task automatic check_literals(input string tag);
`ifdef FFT_UNLOAD_NATURAL_ORDER_EN
    check({tag, "_s1"}, {got_bin[1], got_data[1]}, {10'd1, 32'd512});
    check({tag, "_s2"}, {got_bin[2], got_data[2]}, {10'd2, 32'd256});
    check({tag, "_s3"}, {got_bin[3], got_data[3]}, {10'd3, 32'd768});
`else
    check({tag, "_s1"}, {got_bin[1], got_data[1]}, {10'd512, 32'd1});
    check({tag, "_s2"}, {got_bin[2], got_data[2]}, {10'd256, 32'd2});
    check({tag, "_s3"}, {got_bin[3], got_data[3]}, {10'd768, 32'd3});
`endif
    check({tag, "_last"}, {got_bin[N-1], got_data[N-1], got_last[N-1], got_last[N-2]},
          {10'd1023, 32'd1023, 1'b1, 1'b0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_src_mem1 = 1'b0;
    mon_reset();
    fill(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_rd_en, o_rd_addr, o_valid, o_data, o_bin, o_last, o_busy, o_done}, '0);
    @(negedge clk); rst_n = 1'b1;

    // result in mem1, ready always high
    ready_mode = 0;
    start_run(1'b1);
    wait_done(N + 100);
    check_full_run("mem1", 1'b1);
    check_literals("mem1");

    // result in mem2
    fill(1'b0);
    start_run(1'b0);
    wait_done(N + 100);
    check_full_run("mem2", 1'b1);
    check_literals("mem2");

    // ready pattern 1,0,0,1
    fill(1'b1);
    ready_mode = 1;
    start_run(1'b1);
    wait_done(3 * N);
    check_full_run("ready_pat", 1'b0);
    ready_mode = 0;

    // ready low for 100 cycles after start
    ready_mode = 2;
    start_run(1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("stall_reads", 64'(iss_cnt), 64'(2));
    check("stall_head", {o_valid, o_bin, xfer_cnt[7:0]}, {1'b1, model_bin(0), 8'd0});
    ready_mode = 0;
    wait_done(N + 200);
    check_full_run("stall", 1'b0);

    // reset at sample 300
    start_run(1'b1);
    for (int n = 0; n < 2 * N && xfer_cnt < 300; n++) @(posedge clk);
    check("reached_300", 64'(xfer_cnt >= 300), 64'(1));
    #1;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {o_rd_en, o_rd_addr, o_valid, o_data, o_bin, o_last, o_busy, o_done}, '0);
    @(negedge clk);
    check("reset_held_outputs", {o_rd_en, o_rd_addr, o_valid, o_data, o_bin, o_last, o_busy, o_done}, '0);
    rst_n = 1'b1;
    mon_reset();
    mon_en = 1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt), 64'(0));
    start_run(1'b1);
    wait_done(N + 100);
    check_full_run("restart", 1'b1);

    // start repeated while busy
    start_run(1'b1);
    repeat (10) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (490) @(posedge clk);
    #1 i_start = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(N + 100);
    repeat (5) @(posedge clk);
    #1;
    check_full_run("restart_ignored", 1'b1);
    check("idle_after_run", {o_busy, o_valid}, 2'b00);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
